tmds_decoder: RTL



---
 rtl/tmds_decoder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/tmds_decoder.sv
// One-channel TMDS receive decoder: hunts control-token runs for word alignment, then decodes symbols.
// Define TMDS_DECODER_STATS_EN to add saturating slip_cnt / loss_cnt outputs.
module tmds_decoder #(
    parameter int CTL_RUN        = 8,
    parameter int SEARCH_TIMEOUT = 64,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic        pixclk,
    input  logic        rst_n,
    input  logic [9:0]  sym_in,
    output logic        vde,
    output logic [1:0]  cd,
    output logic [7:0]  vd,
    output logic        locked,
    output logic [3:0]  bit_offset
`ifdef TMDS_DECODER_STATS_EN
    ,
    output logic [15:0] slip_cnt,
    output logic [15:0] loss_cnt
`endif
);

    localparam int RC_W = $clog2(CTL_RUN + 1);
    localparam int TC_W = $clog2(SEARCH_TIMEOUT);
    localparam int LC_W = $clog2(LOSS_TIMEOUT);

    localparam logic [RC_W-1:0] RC_LAST = RC_W'(CTL_RUN - 1);
    localparam logic [TC_W-1:0] TC_MAX  = TC_W'(SEARCH_TIMEOUT - 1);
    localparam logic [LC_W-1:0] LC_MAX  = LC_W'(LOSS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    state_t          state, state_nxt;
    logic [RC_W-1:0] rc, rc_nxt;
    logic [TC_W-1:0] tc, tc_nxt;
    logic [LC_W-1:0] lc, lc_nxt;
    logic            slip;

    logic [9:0]  prev;
    logic [19:0] shifted;
    logic [9:0]  w;
    logic        is_tok;
    logic [1:0]  tok_cd;
    logic [7:0]  d;
    logic [6:0]  dx;
    logic [7:0]  dec;

    // The older word sits in the low half, so higher offsets reach into the current word.
    assign shifted = {sym_in, prev} >> bit_offset;
    assign w       = shifted[9:0];

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        is_tok = 1'b1;
        tok_cd = 2'b00;
        case (w)
            10'b1101010100: tok_cd = 2'b00;
            10'b0010101011: tok_cd = 2'b01;
            10'b0101010100: tok_cd = 2'b10;
            10'b1010101011: tok_cd = 2'b11;
            default:        is_tok = 1'b0;
        endcase
    end

    assign d   = w[9] ? ~w[7:0] : w[7:0];
    assign dx  = d[7:1] ^ d[6:0];
    assign dec = {(w[8] ? dx : ~dx), d[0]};

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_SEARCH;
            rc         <= '0;
            tc         <= '0;
            lc         <= '0;
            prev       <= '0;
            bit_offset <= '0;
        end else begin
            state <= state_nxt;
            rc    <= rc_nxt;
            tc    <= tc_nxt;
            lc    <= lc_nxt;
            prev  <= sym_in;
            if (slip)
                bit_offset <= (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        rc_nxt    = rc;
        tc_nxt    = tc;
        lc_nxt    = lc;
        slip      = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (is_tok) begin
                    state_nxt = ST_VERIFY;
                    rc_nxt    = RC_W'(1);
                    tc_nxt    = '0;
                end else if (tc == TC_MAX) begin
                    tc_nxt = '0;
                    slip   = 1'b1;
                end else begin
                    tc_nxt = tc + TC_W'(1);
                end
            end
            ST_VERIFY: begin
                if (is_tok) begin
                    rc_nxt = rc + RC_W'(1);
                    if (rc == RC_LAST) begin
                        state_nxt = ST_LOCKED;
                        lc_nxt    = '0;
                    end
                end else begin
                    state_nxt = ST_SEARCH;
                    rc_nxt    = '0;
                    tc_nxt    = '0;
                    slip      = 1'b1;
                end
            end
            ST_LOCKED: begin
                // Only token starvation drops lock; data symbols merely age the loss counter.
                if (is_tok) begin
                    lc_nxt = '0;
                end else if (lc == LC_MAX) begin
                    state_nxt = ST_SEARCH;
                    tc_nxt    = '0;
                end else begin
                    lc_nxt = lc + LC_W'(1);
                end
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    assign locked = (state == ST_LOCKED);

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            vde <= 1'b0;
            cd  <= 2'b00;
            vd  <= 8'h00;
        end else if (state == ST_LOCKED) begin
            vde <= !is_tok;
            vd  <= is_tok ? 8'h00 : dec;
            if (is_tok)
                cd <= tok_cd;
        end else begin
            vde <= 1'b0;
            cd  <= 2'b00;
            vd  <= 8'h00;
        end
    end

`ifdef TMDS_DECODER_STATS_EN
    logic loss_evt;
    assign loss_evt = (state == ST_LOCKED) && (state_nxt == ST_SEARCH);

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            slip_cnt <= '0;
            loss_cnt <= '0;
        end else begin
            if (slip && slip_cnt != 16'hFFFF)
                slip_cnt <= slip_cnt + 16'd1;
            if (loss_evt && loss_cnt != 16'hFFFF)
                loss_cnt <= loss_cnt + 16'd1;
        end
    end
`endif

endmodule
